ld_st_control_unit: RTL and testbench

LD_ST_CONTROL_UNIT -- requirements
Module: ld_st_control_unit

---
 rtl/ld_st_control_unit.sv | 127 ++++++++++++
 tb/tb_ld_st_control_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ld_st_control_unit.sv
// Hardwired Moore sequencer for the ld / ldi / st instruction group.
// Outputs decode only from the state register and the opcode latched at the end of T3.
module ld_st_control_unit (
    input  logic       clock,
    input  logic       clear,
    input  logic [4:0] IRop,
    input  logic       MemReady,
    input  logic       Stop,
    output logic       PCout,
    output logic       PCin,
    output logic       IncPC,
    output logic       MARin,
    output logic       MDRin,
    output logic       MDRout,
    output logic       MDMuxread,
    output logic       RAMread,
    output logic       RAMwrite,
    output logic       IRin,
    output logic       Yin,
    output logic       Zlowin,
    output logic       Zlowout,
    output logic       ADD,
    output logic       CSEout,
    output logic       Gra,
    output logic       Grb,
    output logic       Rin,
    output logic       Rout,
    output logic       BAout,
    output logic       Run,
    output logic       Fault
);

    localparam logic [4:0] OP_LD  = 5'b00000;
    localparam logic [4:0] OP_LDI = 5'b00001;
    localparam logic [4:0] OP_ST  = 5'b00010;

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT, FAULT
    } state_t;

    state_t     state;
    logic [4:0] opcode;

    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= RST;
            opcode <= 5'b00000;
        end else begin
            case (state)
                RST: state <= T0;
                T0:  state <= T1;
                T1:  if (MemReady) state <= T2;
                T2:  state <= T3;
                T3: begin
                    opcode <= IRop;
                    state  <= T4;
                end
                T4: begin
                    if (opcode == OP_LD || opcode == OP_LDI || opcode == OP_ST)
                        state <= T5;
                    else
                        state <= FAULT;
                end
                T5: begin
                    if (opcode == OP_LDI)
                        state <= Stop ? HALT : T0;
                    else
                        state <= T6;
                end
                // Only ld waits on memory in T6; st writes in T7 and waits there.
                T6: if (opcode == OP_ST || MemReady) state <= T7;
                T7: if (opcode == OP_LD || MemReady) state <= Stop ? HALT : T0;
                HALT:  if (!Stop) state <= T0;
                FAULT: state <= FAULT;
                default: state <= RST;
            endcase
        end
    end

    always_comb begin
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; MDMuxread = 1'b0; RAMread = 1'b0;
        RAMwrite = 1'b0; IRin = 1'b0; Yin = 1'b0; Zlowin = 1'b0;
        Zlowout = 1'b0; ADD = 1'b0; CSEout = 1'b0; Gra = 1'b0;
        Grb = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        Run = 1'b0; Fault = 1'b0;
        case (state)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; Run = 1'b1; end
            T1: begin
                Zlowout = 1'b1; PCin = 1'b1; RAMread = 1'b1;
                MDMuxread = 1'b1; MDRin = 1'b1; Run = 1'b1;
            end
            T2: begin MDRout = 1'b1; IRin = 1'b1; Run = 1'b1; end
            T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; Run = 1'b1; end
            T4: begin CSEout = 1'b1; ADD = 1'b1; Zlowin = 1'b1; Run = 1'b1; end
            T5: begin
                Run = 1'b1;
                Zlowout = 1'b1;
                if (opcode == OP_LDI) begin
                    Gra = 1'b1; Rin = 1'b1;
                end else begin
                    MARin = 1'b1;
                end
            end
            T6: begin
                Run = 1'b1;
                MDRin = 1'b1;
                if (opcode == OP_ST) begin
                    Gra = 1'b1; Rout = 1'b1;
                end else begin
                    RAMread = 1'b1; MDMuxread = 1'b1;
                end
            end
            T7: begin
                Run = 1'b1;
                if (opcode == OP_ST) begin
                    RAMwrite = 1'b1;
                end else begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            FAULT: Fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ld_st_control_unit.sv
// Directed bench for ld_st_control_unit: checks the packed strobe vector state by state.
module tb_ld_st_control_unit;

    logic       clock = 1'b0;
    logic       clear, MemReady, Stop;
    logic [4:0] IRop;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, RAMwrite;
    logic IRin, Yin, Zlowin, Zlowout, ADD, CSEout, Gra, Grb, Rin, Rout, BAout, Run, Fault;

    int total = 0;
    int bad   = 0;

    ld_st_control_unit dut (
        .clock(clock), .clear(clear), .IRop(IRop), .MemReady(MemReady), .Stop(Stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .MDMuxread(MDMuxread), .RAMread(RAMread), .RAMwrite(RAMwrite),
        .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zlowout(Zlowout), .ADD(ADD),
        .CSEout(CSEout), .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Run(Run), .Fault(Fault)
    );

    always #5 clock = ~clock;

    logic [21:0] obs;
    assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, RAMwrite,
                  IRin, Yin, Zlowin, Zlowout, ADD, CSEout, Gra, Grb, Rin, Rout, BAout,
                  Run, Fault};

    localparam logic [21:0] PCOUT = 22'h1 << 21, PCIN  = 22'h1 << 20, INCPC = 22'h1 << 19;
    localparam logic [21:0] MARIN = 22'h1 << 18, MDRIN = 22'h1 << 17, MDROUT = 22'h1 << 16;
    localparam logic [21:0] MDMUX = 22'h1 << 15, RAMRD = 22'h1 << 14, RAMWR = 22'h1 << 13;
    localparam logic [21:0] IRIN  = 22'h1 << 12, YIN   = 22'h1 << 11, ZLIN  = 22'h1 << 10;
    localparam logic [21:0] ZLOUT = 22'h1 << 9,  ADDB  = 22'h1 << 8,  CSE   = 22'h1 << 7;
    localparam logic [21:0] GRA   = 22'h1 << 6,  GRB   = 22'h1 << 5,  RIN   = 22'h1 << 4;
    localparam logic [21:0] ROUT  = 22'h1 << 3,  BAOUT = 22'h1 << 2,  RUN   = 22'h1 << 1;
    localparam logic [21:0] FLT   = 22'h1;

    localparam logic [21:0] E_NONE = 22'h0;
    localparam logic [21:0] E_T0   = PCOUT | MARIN | INCPC | ZLIN | RUN;
    localparam logic [21:0] E_T1   = ZLOUT | PCIN | RAMRD | MDMUX | MDRIN | RUN;
    localparam logic [21:0] E_T2   = MDROUT | IRIN | RUN;
    localparam logic [21:0] E_T3   = GRB | BAOUT | YIN | RUN;
    localparam logic [21:0] E_T4   = CSE | ADDB | ZLIN | RUN;
    localparam logic [21:0] E_LD5  = ZLOUT | MARIN | RUN;
    localparam logic [21:0] E_LD6  = RAMRD | MDMUX | MDRIN | RUN;
    localparam logic [21:0] E_LD7  = MDROUT | GRA | RIN | RUN;
    localparam logic [21:0] E_LDI5 = ZLOUT | GRA | RIN | RUN;
    localparam logic [21:0] E_ST6  = GRA | ROUT | MDRIN | RUN;
    localparam logic [21:0] E_ST7  = RAMWR | RUN;
    localparam logic [21:0] E_FLT  = FLT;

    task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %06h want %06h", tag, got, want);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input string tag);
        step; chk({tag, "_t1"}, obs, E_T1);
        step; chk({tag, "_t2"}, obs, E_T2);
        step; chk({tag, "_t3"}, obs, E_T3);
        step; chk({tag, "_t4"}, obs, E_T4);
    endtask

    initial begin
        clear = 1'b1; IRop = 5'b00000; MemReady = 1'b1; Stop = 1'b0;

        // ld with memory always ready: 8 cycles, T0 again on the 9th
        step; chk("rst", obs, E_NONE);
        clear = 1'b0;
        step; chk("ld_t0", obs, E_T0);
        fetch("ld");
        step; chk("ld_t5", obs, E_LD5);
        step; chk("ld_t6", obs, E_LD6);
        step; chk("ld_t7", obs, E_LD7);
        step; chk("ld_next_t0", obs, E_T0);

        // ldi; IRop changed after T3 must not affect the latched path
        IRop = 5'b00001;
        fetch("ldi");
        IRop = 5'b11111;
        step; chk("ldi_t5", obs, E_LDI5);
        step; chk("ldi_next_t0", obs, E_T0);

        // st with a 3-cycle write wait in T7; MemReady low in T6 is ignored
        IRop = 5'b00010;
        fetch("st");
        step; chk("st_t5", obs, E_LD5);
        MemReady = 1'b0;
        step; chk("st_t6", obs, E_ST6);
        step; chk("st_t7_0", obs, E_ST7);
        step; chk("st_t7_1", obs, E_ST7);
        step; chk("st_t7_2", obs, E_ST7);
        step; chk("st_t7_3", obs, E_ST7);
        MemReady = 1'b1;
        step; chk("st_next_t0", obs, E_T0);

        // illegal opcode locks in FAULT until clear
        IRop = 5'b11111;
        fetch("bad");
        step; chk("fault_0", obs, E_FLT);
        Stop = 1'b1;
        step; chk("fault_1", obs, E_FLT);
        Stop = 1'b0;
        step; chk("fault_2", obs, E_FLT);
        clear = 1'b1;
        step; chk("fault_clr", obs, E_NONE);
        clear = 1'b0;
        step; chk("after_fault_t0", obs, E_T0);

        // ld with Stop held high: only T7 samples it, then HALT until Stop drops
        IRop = 5'b00000; Stop = 1'b1;
        fetch("ldh");
        step; chk("ldh_t5", obs, E_LD5);
        step; chk("ldh_t6", obs, E_LD6);
        step; chk("ldh_t7", obs, E_LD7);
        step; chk("halt_0", obs, E_NONE);
        step; chk("halt_1", obs, E_NONE);
        Stop = 1'b0;
        step; chk("resume_t0", obs, E_T0);

        // T1 wait, then clear in the middle of the ld T6 wait
        MemReady = 1'b0;
        step; chk("w_t1_0", obs, E_T1);
        step; chk("w_t1_1", obs, E_T1);
        MemReady = 1'b1;
        step; chk("w_t2", obs, E_T2);
        step; chk("w_t3", obs, E_T3);
        step; chk("w_t4", obs, E_T4);
        step; chk("w_t5", obs, E_LD5);
        MemReady = 1'b0;
        step; chk("w_t6_0", obs, E_LD6);
        step; chk("w_t6_1", obs, E_LD6);
        clear = 1'b1;
        step; chk("w_clr", obs, E_NONE);
        clear = 1'b0; MemReady = 1'b1;
        step; chk("w_after_t0", obs, E_T0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
